// File: rtl/kick_dribble_ctrl.sv
// kick_dribble_ctrl: dribbler enable level plus a strength-scaled kick solenoid
// pulse with a mandatory recharge lockout after every kick.
// Optional watchdog: define KICK_DRIBBLE_WATCHDOG_EN to stop the dribbler
// after WDOG_CYCLES idle cycles and raise a sticky wdog_trip flag.
module kick_dribble_ctrl #(
  parameter int CMD_W       = 8,
  parameter int DRIB_BIT    = 7,
  parameter int KICK_W      = 4,
  parameter int PULSE_UNIT  = 100,
  parameter int COOLDOWN    = 5000,
  parameter int WDOG_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd,
  output logic             dribbler_out,
  output logic             kick_out,
  output logic             kick_busy,
  output logic             kick_drop,
  output logic             wdog_trip
);

  // One counter serves both the pulse and the cooldown, so size it for the larger.
  localparam int MAX_PULSE = ((1 << KICK_W) - 1) * PULSE_UNIT;
  localparam int MAX_CNT   = (MAX_PULSE > COOLDOWN) ? MAX_PULSE : COOLDOWN;
  localparam int CNT_W     = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_COOL} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kick_out_q, kick_out_d;
  logic             kick_busy_q, kick_busy_d;
  logic             kick_drop_q, kick_drop_d;
  logic             drib_q;

  logic [KICK_W-1:0] strength;
  logic              kick_req;
  logic [CNT_W-1:0]  pulse_len;
  logic              unused_cmd;

  assign strength  = cmd[KICK_W-1:0];
  assign kick_req  = cmd_valid && (strength != '0);
  assign pulse_len = CNT_W'(int'(strength) * PULSE_UNIT);
  assign unused_cmd = ^cmd;

  // FSM state and shared pulse/cooldown counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: counter holds the remaining cycles of the current phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (kick_req) begin
          state_d = S_FIRE;
          cnt_d   = pulse_len;
        end
      end
      S_FIRE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_COOL;
          cnt_d   = CNT_W'(COOLDOWN);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_COOL: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs derived from the next state so the registered copies line up with it
  always_comb begin
    kick_out_d  = (state_d == S_FIRE);
    kick_busy_d = (state_d != S_IDLE);
    kick_drop_d = kick_req && (state_q != S_IDLE);
  end

  // Registered kick outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      kick_out_q  <= 1'b0;
      kick_busy_q <= 1'b0;
      kick_drop_q <= 1'b0;
    end else begin
      kick_out_q  <= kick_out_d;
      kick_busy_q <= kick_busy_d;
      kick_drop_q <= kick_drop_d;
    end
  end

`ifdef KICK_DRIBBLE_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES);

  logic [WD_W-1:0] wd_q;
  logic            trip_q;

  // Dribbler follows each valid word; an idle stretch of WDOG_CYCLES forces it off
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q   <= '0;
      trip_q <= 1'b0;
      drib_q <= 1'b0;
    end else if (cmd_valid) begin
      wd_q   <= '0;
      trip_q <= 1'b0;
      drib_q <= cmd[DRIB_BIT];
    end else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
      trip_q <= 1'b1;
      drib_q <= 1'b0;
    end else begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  assign wdog_trip = trip_q;
`else
  localparam int unused_wdog = WDOG_CYCLES;

  // Dribbler follows each valid word and otherwise holds
  always_ff @(posedge clk) begin
    if (rst) begin
      drib_q <= 1'b0;
    end else if (cmd_valid) begin
      drib_q <= cmd[DRIB_BIT];
    end
  end

  assign wdog_trip = 1'b0;
`endif

  assign dribbler_out = drib_q;
  assign kick_out     = kick_out_q;
  assign kick_busy    = kick_busy_q;
  assign kick_drop    = kick_drop_q;

endmodule

// File: tb/tb_kick_dribble_ctrl.sv
// Directed bench for kick_dribble_ctrl with PULSE_UNIT=4, COOLDOWN=10,
// WDOG_CYCLES=20. Watchdog expectations follow KICK_DRIBBLE_WATCHDOG_EN.
module tb_kick_dribble_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       dribbler_out, kick_out, kick_busy, kick_drop, wdog_trip;

  int checks = 0;
  int errors = 0;
  int hi_n = 0;
  int b_n = 0;

  kick_dribble_ctrl #(
    .PULSE_UNIT (4),
    .COOLDOWN   (10),
    .WDOG_CYCLES(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .dribbler_out(dribbler_out),
    .kick_out    (kick_out),
    .kick_busy   (kick_busy),
    .kick_drop   (kick_drop),
    .wdog_trip   (wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1 ns after the edge
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic tally;
    if (kick_out) hi_n++;
    if (kick_busy) b_n++;
  endtask

  // run until kick_busy drops, tallying every observed cycle
  task automatic drain;
    int g = 0;
    while (kick_busy && g < 200) begin
      tally();
      step();
      g++;
    end
    chk("drain_bound", (g < 200), 1);
  endtask

  task automatic send(input logic [7:0] c);
    cmd = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_drib", dribbler_out, 0);
    chk("rst_kick", kick_out, 0);
    chk("rst_busy", kick_busy, 0);
    chk("rst_drop", kick_drop, 0);
    chk("rst_trip", wdog_trip, 0);
    rst = 1'b0;
    step();

    // dribbler only
    send(8'h80);
    chk("drib_on", dribbler_out, 1);
    chk("drib_nokick", kick_out, 0);
    chk("drib_nobusy", kick_busy, 0);
    step();
    chk("drib_nokick2", kick_out, 0);

    // strength 3: 12-cycle pulse, 22 busy, then immediate re-accept
    hi_n = 0; b_n = 0;
    send(8'h03);
    chk("k3_first", kick_out, 1);
    chk("k3_drib_off", dribbler_out, 0);
    drain();
    chk("k3_pulse", hi_n, 12);
    chk("k3_busy", b_n, 22);
    hi_n = 0; b_n = 0;
    send(8'h01);
    chk("k1_accept", kick_out, 1);
    drain();
    chk("k1_pulse", hi_n, 4);
    chk("k1_busy", b_n, 14);

    // strength 5 with a rejected kick during FIRE
    step();
    hi_n = 0; b_n = 0;
    send(8'h05);
    tally();
    send(8'h82);
    chk("drop_hi", kick_drop, 1);
    chk("drop_drib", dribbler_out, 1);
    tally();
    step();
    chk("drop_lo", kick_drop, 0);
    drain();
    chk("k5_pulse", hi_n, 20);
    chk("k5_busy", b_n, 30);
    chk("k5_no_drop", kick_drop, 0);

    // reset on the 3rd cycle of a strength-15 kick
    send(8'h0F);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstk_kick", kick_out, 0);
    chk("rstk_busy", kick_busy, 0);
    chk("rstk_drib", dribbler_out, 0);
    hi_n = 0; b_n = 0;
    send(8'h01);
    chk("rstk_accept", kick_out, 1);
    drain();
    chk("rstk_pulse", hi_n, 4);
    chk("rstk_busy_n", b_n, 14);

    // watchdog: 20 idle cycles after a dribbler command
    send(8'h80);
    chk("wd_drib_on", dribbler_out, 1);
    repeat (19) step();
    chk("wd_pre_drib", dribbler_out, 1);
    chk("wd_pre_trip", wdog_trip, 0);
    step();
`ifdef KICK_DRIBBLE_WATCHDOG_EN
    chk("wd_exp_drib", dribbler_out, 0);
    chk("wd_exp_trip", wdog_trip, 1);
`else
    chk("wd_exp_drib", dribbler_out, 1);
    chk("wd_exp_trip", wdog_trip, 0);
`endif
    send(8'h80);
    chk("wd_clr_trip", wdog_trip, 0);
    chk("wd_clr_drib", dribbler_out, 1);

    // valid lands exactly on the expiry cycle
    repeat (19) step();
    send(8'h80);
    chk("wd_race_trip", wdog_trip, 0);
    chk("wd_race_drib", dribbler_out, 1);
    step();
    chk("wd_race_trip2", wdog_trip, 0);
    chk("wd_race_drib2", dribbler_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
